// File: rtl/line_memory.sv
// line_memory: word-addressed backing store for a cache, returning aligned
// 4-word lines on reads and accepting single-word writes, with a fixed
// access latency.
//
// Ports:
//   clk            - single clock, rising edge
//   reset_n        - synchronous active-low reset
//   readM          - line-read request (ignored while busy)
//   writeM         - word-write request (wins over readM when both are high)
//   addressM       - word address; only the low DEPTH_LOG2 bits index the array
//   data_mem_cache - shared line bus: low word carries write data, full width
//                    carries read returns during the read DONE cycle only
//   read_done      - one-cycle pulse, read data valid on data_mem_cache
//   write_done     - one-cycle pulse, write completes at the end of this cycle
//   busy           - high while an access is in WAIT or DONE
//   num_mem_read   - completed line reads (wrapping)
//   num_mem_write  - completed word writes (wrapping)
module line_memory #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned READ_SIZE  = 64,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] addressM,
    inout  wire  [READ_SIZE-1:0] data_mem_cache,
    output logic                 read_done,
    output logic                 write_done,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] num_mem_read,
    output logic [WORD_SIZE-1:0] num_mem_write
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  is_read_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [WORD_SIZE-1:0]  wdata_q;
    logic [READ_SIZE-1:0]  line_q;
    logic                  busy_d;
    logic                  read_done_d;
    logic                  write_done_d;
    logic                  accept;

    logic [WORD_SIZE-1:0]  mem [0:DEPTH-1];

    // Upper address bits alias by design; upper bus bits are only driven here.
    logic unused_bits;
    assign unused_bits = ^{addressM[WORD_SIZE-1:DEPTH_LOG2],
                           data_mem_cache[READ_SIZE-1:WORD_SIZE]};

    assign accept = (state_q == IDLE) && (readM || writeM);

    // State register plus registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            read_done  <= 1'b0;
            write_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= busy_d;
            read_done  <= read_done_d;
            write_done <= write_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (readM || writeM) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the outputs line up with it once registered.
    always_comb begin
        busy_d       = 1'b0;
        read_done_d  = 1'b0;
        write_done_d = 1'b0;
        busy_d       = (state_d != IDLE);
        if (state_d == DONE) begin
            read_done_d  = is_read_q;
            write_done_d = !is_read_q;
        end
    end

    // Request latching, latency counter and completion counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            is_read_q     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            num_mem_read  <= '0;
            num_mem_write <= '0;
        end else begin
            if (accept) begin
                cnt_q     <= CNT_W'(LATENCY - 2);
                is_read_q <= !writeM;
                addr_q    <= addressM[DEPTH_LOG2-1:0];
                wdata_q   <= data_mem_cache[WORD_SIZE-1:0];
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_q == DONE) begin
                if (is_read_q) num_mem_read  <= num_mem_read + WORD_SIZE'(1);
                else           num_mem_write <= num_mem_write + WORD_SIZE'(1);
            end
        end
    end

    // Array: not reset; write commits at the end of DONE unless reset aborts it.
    // The line is captured on entry to DONE, so an earlier write is always visible.
    always_ff @(posedge clk) begin
        if (reset_n && (state_q == DONE) && !is_read_q) begin
            mem[addr_q] <= wdata_q;
        end
        if ((state_q == WAIT) && (state_d == DONE)) begin
            for (int i = 0; i < 4; i++) begin
                line_q[WORD_SIZE*i +: WORD_SIZE] <= mem[{addr_q[DEPTH_LOG2-1:2], 2'(i)}];
            end
        end
    end

    // Bus is driven only in the read DONE cycle, which read_done marks exactly.
    assign data_mem_cache = read_done ? line_q : {READ_SIZE{1'bz}};

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter WORD_SIZE, default 16: word width in bits.
REQ-002 Parameter READ_SIZE, default 64: line width, fixed at 4*WORD_SIZE.
REQ-003 Parameter LATENCY, default 4: cycles from request acceptance to done pulse; legal range 2..15.
REQ-004 Parameter DEPTH_LOG2, default 8: the array holds 2^DEPTH_LOG2 words.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 readM  input  1  line-read request from the cache.
REQ-008 writeM  input  1  word-write request from the cache.
REQ-009 addressM  input  WORD_SIZE  word address of the request.
REQ-010 data_mem_cache  inout  READ_SIZE  shared line bus: the cache drives it for writes; this block drives it for read returns.
REQ-011 read_done  output  1  one-cycle pulse that marks read data valid on data_mem_cache.
REQ-012 write_done  output  1  one-cycle pulse that marks write completion.
REQ-013 busy  output  1  high while an access is in progress (WAIT or DONE).
REQ-014 num_mem_read  output  WORD_SIZE  count of completed line reads.
REQ-015 num_mem_write  output  WORD_SIZE  count of completed word writes.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-017 In IDLE, readM or writeM high SHALL be accepted at the clock edge; addressM, the request type and data_mem_cache[WORD_SIZE-1:0] (for a write) SHALL be latched at that edge; the latency counter SHALL load LATENCY-2; the next state SHALL be WAIT.
REQ-018 If readM and writeM are both high in IDLE, only the write SHALL be accepted; the read SHALL be served only if it is still asserted in a later IDLE cycle.
REQ-019 In WAIT, the counter SHALL decrement by one each cycle; when the counter is 0 the next state SHALL be DONE.
REQ-020 Acceptance at the end of cycle 0 SHALL produce the done pulse in cycle LATENCY, so WAIT lasts LATENCY-1 cycles.
REQ-021 In DONE, read_done or write_done (matching the latched type) SHALL be high for exactly that cycle; the next state SHALL be IDLE unconditionally.
REQ-022 readM, writeM, addressM and write data SHALL be ignored in WAIT and DONE; changes mid-access SHALL have no effect.
REQ-023 A line read SHALL return the words at index {A[DEPTH_LOG2-1:2],2'b00}+i for i=0..3, with word i placed on data_mem_cache[WORD_SIZE*i +: WORD_SIZE] (lowest address in the LSBs).
REQ-024 The index A SHALL be addressM[DEPTH_LOG2-1:0]; upper address bits SHALL be ignored, so higher addresses alias.
REQ-025 A write SHALL update only array[A] with the latched word, at the clock edge that ends the DONE cycle.
REQ-026 A read accepted in a later IDLE cycle SHALL observe that write.
REQ-027 data_mem_cache SHALL be driven only during a read DONE cycle; in every other cycle it SHALL be high-Z.
REQ-028 num_mem_read and num_mem_write SHALL each increment by 1 at the end of the corresponding DONE cycle, and SHALL wrap from 16'hFFFF to 0.
REQ-029 busy SHALL be low in IDLE and high in WAIT and DONE.
REQ-030 Back-to-back accesses: a request held through DONE SHALL be accepted in the IDLE cycle that follows, so the minimum request spacing is LATENCY+1 cycles.

Reset
REQ-031 When reset_n is low at a clock edge, the state SHALL become IDLE; read_done, write_done and busy SHALL be 0; both counters SHALL be 0; data_mem_cache SHALL be high-Z.
REQ-032 Reset during WAIT or DONE SHALL abort the access, produce no done pulse, commit no pending write and leave the counters at 0.
REQ-033 Array contents SHALL NOT be affected by reset; contents are undefined until written.
REQ-034 A request asserted in the first cycle with reset_n high SHALL be accepted normally.

Verification
REQ-035 Write latency: write addr 16'h0005, data 16'hBEEF, readM low -> write_done high exactly in cycle 4, busy high in cycles 1-4, num_mem_write=1.
REQ-036 Line read: after writes 16'h1111/2222/3333/4444 to addrs 4-7, a read at addr 16'h0006 -> read_done in cycle 4 with data_mem_cache=64'h4444_3333_2222_1111, bus high-Z in cycles 3 and 5.
REQ-037 Simultaneous request: readM and writeM both high in IDLE at addr 9 with data 16'hA5A5 -> write_done only; a read held afterwards at addr 8 returns word1=16'hA5A5; counters = 1/1.
REQ-038 Reset mid-write: write to addr 2 with data 16'h7777, reset_n low in cycle 2 -> no write_done, a later read of addr 2 does not return 16'h7777, num_mem_write=0.
REQ-039 Aliasing and wrap: a write to addr 16'h0103 is read back at addr 16'h0003; counter preload to 16'hFFFF plus one completed read -> num_mem_read=0.
REQ-040 Mid-access change: addressM changed and readM dropped during WAIT -> the original latched address is returned and read_done still pulses in cycle 4.
